// File: rtl/boot_rom_prefetch_pkg.sv
// Shared types for the boot-ROM read adapter: prefetch FSM states, response
// source selector and the byte-address to word-index helper.
package boot_rom_prefetch_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PF_PEND = 2'd1,
    PF_FILL = 2'd2
  } pf_state_e;

  typedef enum logic [1:0] {
    ROM = 2'd0,
    BUF = 2'd1,
    ERR = 2'd2
  } rsp_src_e;

  // Caller keeps only the low index bits it needs.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/boot_rom_pf_buffer.sv
// One-word prefetch buffer: data, tag and valid registers plus tag compares
// for a set of lookup indices.
module boot_rom_pf_buffer
  import boot_rom_prefetch_pkg::*;
#(
  parameter int unsigned IDX_W  = 11,
  parameter int unsigned N_LOOK = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         fill_i,
  input  logic [IDX_W-1:0]             fill_idx_i,
  input  logic [DATA_W-1:0]            fill_data_i,
  input  logic [N_LOOK-1:0][IDX_W-1:0] look_idx_i,
  output logic [N_LOOK-1:0]            look_hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic              valid_q;
  logic [IDX_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_idx_i;
      data_q  <= fill_data_i;
    end
  end

  for (genvar gi = 0; gi < N_LOOK; gi++) begin : g_look
    assign look_hit_o[gi] = valid_q && (tag_q == look_idx_i[gi]);
  end

  assign data_o = data_q;

endmodule

// File: rtl/boot_rom_prefetch.sv
// Boot-ROM read adapter: req/gnt/rvalid front end, chip-select ROM port and a
// one-word sequential prefetcher that fills ROM idle cycles.
module boot_rom_prefetch
  import boot_rom_prefetch_pkg::*;
#(
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter bit          PREFETCH_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0] rom_addr_o,
  input  logic [DATA_W-1:0]         rom_rdata_i,
  output logic [CNT_WIDTH-1:0]      hit_cnt_o
);

  localparam int unsigned IDX_W = ROM_ADDR_WIDTH - 2;

  logic [31:0]           word_full;
  logic                  unused_word_hi;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      pf_cand;
  logic                  req_ok;
  logic                  rd_req;
  logic                  wr_req;
  logic                  buf_hit;
  logic                  pend_hit;
  logic                  miss;
  logic                  pf_covered;
  logic                  new_pf;
  logic                  pf_issue;
  logic [1:0][IDX_W-1:0] look_idx;
  logic [1:0]            look_hit;
  logic [DATA_W-1:0]     buf_data;

  pf_state_e         state_q, state_d;
  logic [IDX_W-1:0]  pf_idx_q, pf_idx_d;
  logic              rvalid_q;
  rsp_src_e          rsp_src_q, rsp_src_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;

  assign word_full      = word_index(addr_i);
  assign idx            = word_full[IDX_W-1:0];
  assign unused_word_hi = ^word_full[31:IDX_W];

  // A request seen while reset is held is neither served nor answered.
  assign req_ok = req_i & ~rst_i;
  assign rd_req = req_ok & ~we_i;
  assign wr_req = req_ok & we_i;

  assign pf_cand     = idx + IDX_W'(1);
  assign look_idx[0] = idx;
  assign look_idx[1] = pf_cand;

  boot_rom_pf_buffer #(
    .IDX_W  (IDX_W),
    .N_LOOK (2)
  ) u_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fill_i      (state_q == PF_FILL),
    .fill_idx_i  (pf_idx_q),
    .fill_data_i (rom_rdata_i),
    .look_idx_i  (look_idx),
    .look_hit_o  (look_hit),
    .data_o      (buf_data)
  );

  assign buf_hit  = rd_req & look_hit[0];
  assign pend_hit = rd_req & ~buf_hit & (state_q == PF_FILL) & (idx == pf_idx_q);
  assign miss     = rd_req & ~buf_hit & ~pend_hit;

  // While filling, the buffer is about to hold pf_idx_q, not its current tag.
  assign pf_covered = (state_q == PF_FILL) ? (pf_idx_q == pf_cand) : look_hit[1];
  assign new_pf     = PREFETCH_EN & rd_req & (idx != {IDX_W{1'b1}}) & ~pf_covered;

  // A pending prefetch that a fresh read has just retargeted is dropped, not issued.
  assign pf_issue = (state_q == PF_PEND) & ~miss & ~(new_pf & (pf_cand != pf_idx_q));

  assign rom_csn_o  = ~(miss | pf_issue);
  assign rom_addr_o = miss ? idx : (pf_issue ? pf_idx_q : '0);

  always_comb begin
    state_d  = state_q;
    pf_idx_d = pf_idx_q;
    unique case (state_q)
      IDLE: begin
        if (new_pf) begin
          state_d  = PF_PEND;
          pf_idx_d = pf_cand;
        end
      end
      PF_PEND: begin
        if (pf_issue) begin
          state_d = PF_FILL;
        end else if (new_pf) begin
          pf_idx_d = pf_cand;
        end
      end
      PF_FILL: begin
        if (new_pf) begin
          state_d  = PF_PEND;
          pf_idx_d = pf_cand;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pf_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      pf_idx_q <= pf_idx_d;
    end
  end

  // A pending hit takes the prefetch word straight off the ROM bus as it lands.
  assign rsp_src_d  = wr_req ? ERR : ((buf_hit | pend_hit) ? BUF : ROM);
  assign rsp_data_d = pend_hit ? rom_rdata_i : buf_data;
  assign hit_cnt_d  = ((buf_hit | pend_hit) && (hit_cnt_q != {CNT_WIDTH{1'b1}}))
                    ? hit_cnt_q + CNT_WIDTH'(1) : hit_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      rsp_src_q  <= ROM;
      rsp_data_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      rvalid_q   <= req_ok;
      rsp_src_q  <= rsp_src_d;
      rsp_data_q <= rsp_data_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rvalid_q) begin
      unique case (rsp_src_q)
        ROM:     rdata_o = rom_rdata_i;
        BUF:     rdata_o = rsp_data_q;
        default: rdata_o = '0;
      endcase
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_q;
  assign err_o     = rvalid_q & (rsp_src_q == ERR);
  assign hit_cnt_o = hit_cnt_q;

endmodule
